// File: rtl/ascon_pkg.sv
// Shared widths and serializer state encoding for the ASCON output path.
package ascon_pkg;

    localparam int CIPHER_WIDTH = 64;
    localparam int TAG_WIDTH    = 128;
    localparam int OUT_WIDTH    = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CIPHER_HI,
        S_CIPHER_LO,
        S_TAG_0,
        S_TAG_1,
        S_TAG_2,
        S_TAG_3
    } ser_state_e;

    function automatic logic is_tag_state(input ser_state_e s);
        return s inside {S_TAG_0, S_TAG_1, S_TAG_2, S_TAG_3};
    endfunction

endpackage

// File: rtl/ascon_sync_fifo.sv
// Show-ahead synchronous FIFO; a push into a full FIFO succeeds only when a pop happens in the same cycle.
module ascon_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop    = pop_i && !empty_o;
    assign do_push   = push_i && (!full_o || do_pop);
    assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    end

    always_ff @(posedge clock_i) begin
        if (reset_i || clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clock_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
        end
    end

endmodule

// File: rtl/ascon_output_serializer.sv
// Buffers 64-bit cipher words and the 128-bit tag from the ASCON core and streams them as 32-bit words.
module ascon_output_serializer
    import ascon_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    i_sys_enable,
    input  logic                    i_valid_cipher,
    input  logic [CIPHER_WIDTH-1:0] i_cipher,
    input  logic                    i_done,
    input  logic [TAG_WIDTH-1:0]    i_tag,
    input  logic                    i_out_ready,
    output logic                    o_out_valid,
    output logic [OUT_WIDTH-1:0]    o_out_data,
    output logic                    o_out_is_tag,
    output logic                    o_out_last,
    output logic                    o_overflow,
    output logic                    o_busy
);

    ser_state_e               state_q, state_d;
    logic                     cap_cipher_q, cap_tag_q;
    logic                     tag_pending_q, tag_pending_d;
    logic                     overflow_q, overflow_d;
    logic [TAG_WIDTH-1:0]     tag_q, tag_d;
    logic [TAG_WIDTH-1:0]     out_buf_q, out_buf_d;

    logic                     fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CIPHER_WIDTH-1:0]  fifo_rd_data, cipher_src;
    logic                     xfer, cipher_avail, load_cipher, tag_done;
    logic                     tag_accept, tag_drop, cipher_drop;

    ascon_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CIPHER_WIDTH)
    ) u_fifo (
        .clock_i   (clock),
        .reset_i   (reset),
        .clear_i   (!i_sys_enable),
        .push_i    (fifo_push),
        .wr_data_i (i_cipher),
        .pop_i     (fifo_pop),
        .rd_data_o (fifo_rd_data),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    assign xfer         = (state_q != S_IDLE) && i_out_ready;
    // A word still in its capture cycle bypasses the empty FIFO so it reaches the output one cycle sooner.
    assign cipher_avail = !fifo_empty || cap_cipher_q;
    assign cipher_src   = fifo_empty ? i_cipher : fifo_rd_data;

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d     = state_q;
        out_buf_d   = out_buf_q;
        load_cipher = 1'b0;
        tag_done    = 1'b0;

        if (xfer) begin
            out_buf_d = {out_buf_q[TAG_WIDTH-OUT_WIDTH-1:0], {OUT_WIDTH{1'b0}}};
        end

        case (state_q)
            S_IDLE: begin
                if (cipher_avail) begin
                    load_cipher = 1'b1;
                    state_d     = S_CIPHER_HI;
                end else if (tag_pending_q) begin
                    out_buf_d = tag_q;
                    state_d   = S_TAG_0;
                end else if (cap_tag_q) begin
                    out_buf_d = i_tag;
                    state_d   = S_TAG_0;
                end
            end
            S_CIPHER_HI: if (xfer) state_d = S_CIPHER_LO;
            S_CIPHER_LO: begin
                if (xfer) begin
                    if (cipher_avail) begin
                        load_cipher = 1'b1;
                        state_d     = S_CIPHER_HI;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_TAG_0: if (xfer) state_d = S_TAG_1;
            S_TAG_1: if (xfer) state_d = S_TAG_2;
            S_TAG_2: if (xfer) state_d = S_TAG_3;
            S_TAG_3: begin
                if (xfer) begin
                    tag_done = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (load_cipher) begin
            out_buf_d = {cipher_src, {(TAG_WIDTH-CIPHER_WIDTH){1'b0}}};
        end
    end

    always_comb begin
        fifo_pop      = load_cipher && !fifo_empty;
        fifo_push     = cap_cipher_q && !(load_cipher && fifo_empty);
        cipher_drop   = fifo_push && fifo_full && !fifo_pop;
        // The tag slot frees on the final tag transfer, so a capture in that same cycle is kept.
        tag_accept    = cap_tag_q && (!tag_pending_q || tag_done);
        tag_drop      = cap_tag_q && !tag_accept;
        tag_d         = tag_accept ? i_tag : tag_q;
        tag_pending_d = tag_accept || (tag_pending_q && !tag_done);
        overflow_d    = overflow_q || cipher_drop || tag_drop;
    end

    // Disabling the system clears the block exactly as reset does.
    always_ff @(posedge clock) begin
        if (reset || !i_sys_enable) begin
            state_q       <= S_IDLE;
            cap_cipher_q  <= 1'b0;
            cap_tag_q     <= 1'b0;
            tag_pending_q <= 1'b0;
            overflow_q    <= 1'b0;
            tag_q         <= '0;
            out_buf_q     <= '0;
        end else begin
            state_q       <= state_d;
            cap_cipher_q  <= i_valid_cipher;
            cap_tag_q     <= i_done;
            tag_pending_q <= tag_pending_d;
            overflow_q    <= overflow_d;
            tag_q         <= tag_d;
            out_buf_q     <= out_buf_d;
        end
    end

    assign o_out_valid  = (state_q != S_IDLE);
    assign o_out_data   = out_buf_q[TAG_WIDTH-1 -: OUT_WIDTH];
    assign o_out_is_tag = is_tag_state(state_q);
    assign o_out_last   = (state_q == S_TAG_3);
    assign o_overflow   = overflow_q;
    assign o_busy       = !fifo_empty || tag_pending_q || cap_cipher_q || cap_tag_q ||
                          (state_q != S_IDLE);

endmodule

// File: tb/tb_ascon_output_serializer.sv
// Self-checking bench: drives cipher/tag pulses and compares the output stream against a word-queue model.
module tb_ascon_output_serializer;
    import ascon_pkg::*;

    localparam int DEPTH = 4;

    logic          clock = 1'b0;
    logic          reset, i_sys_enable, i_valid_cipher, i_done, i_out_ready;
    logic [63:0]   i_cipher;
    logic [127:0]  i_tag;
    logic          o_out_valid, o_out_is_tag, o_out_last, o_overflow, o_busy;
    logic [31:0]   o_out_data;

    always #5 clock = ~clock;

    ascon_output_serializer #(.FIFO_DEPTH(DEPTH)) dut (
        .clock          (clock),
        .reset          (reset),
        .i_sys_enable   (i_sys_enable),
        .i_valid_cipher (i_valid_cipher),
        .i_cipher       (i_cipher),
        .i_done         (i_done),
        .i_tag          (i_tag),
        .i_out_ready    (i_out_ready),
        .o_out_valid    (o_out_valid),
        .o_out_data     (o_out_data),
        .o_out_is_tag   (o_out_is_tag),
        .o_out_last     (o_out_last),
        .o_overflow     (o_overflow),
        .o_busy         (o_busy)
    );

    typedef struct packed {
        logic        is_tag;
        logic        last;
        logic [31:0] data;
    } word_t;

    word_t exp_q[$];
    int    vectors     = 0;
    int    miscompares = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Model: each accepted cipher word is two output words, high half first; a tag is four, last on the final one.
    task automatic model_cipher(input logic [63:0] c);
        exp_q.push_back('{1'b0, 1'b0, c[63:32]});
        exp_q.push_back('{1'b0, 1'b0, c[31:0]});
    endtask

    task automatic model_tag(input logic [127:0] t);
        exp_q.push_back('{1'b1, 1'b0, t[127:96]});
        exp_q.push_back('{1'b1, 1'b0, t[95:64]});
        exp_q.push_back('{1'b1, 1'b0, t[63:32]});
        exp_q.push_back('{1'b1, 1'b1, t[31:0]});
    endtask

    // One clock cycle. Pulses are high for this cycle; the core's registers show the new value next cycle.
    task automatic cycle(input logic vc, input logic [63:0] cd, input logic dn,
                         input logic [127:0] td, input logic rdy);
        logic en;
        en             = !reset && i_sys_enable;
        i_valid_cipher = vc;
        i_done         = dn;
        i_out_ready    = rdy;
        @(posedge clock);
        #1;
        i_valid_cipher = 1'b0;
        i_done         = 1'b0;
        if (vc) begin
            i_cipher = cd;
            if (en) model_cipher(cd);
        end
        if (dn) begin
            i_tag = td;
            if (en) model_tag(td);
        end
    endtask

    task automatic drain(input logic rand_ready, input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || o_busy) && n < 400) begin
            cycle(1'b0, '0, 1'b0, '0, rand_ready ? ($urandom_range(3) != 0) : 1'b1);
            n++;
        end
        check({tag, "_drained"}, {exp_q.size() == 0, o_busy}, 2'b10);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_valid"},  o_out_valid,  1'b0);
        check({tag, "_data"},   o_out_data,   32'h0);
        check({tag, "_is_tag"}, o_out_is_tag, 1'b0);
        check({tag, "_last"},   o_out_last,   1'b0);
        check({tag, "_ovf"},    o_overflow,   1'b0);
        check({tag, "_busy"},   o_busy,       1'b0);
    endtask

    // Monitor: compares every transfer against the model and checks that stalled words hold steady.
    logic  hold_v = 1'b0;
    word_t held, mon_cur, mon_exp;

    always @(negedge clock) begin
        if (reset || !i_sys_enable) begin
            hold_v = 1'b0;
        end else begin
            mon_cur = '{o_out_is_tag, o_out_last, o_out_data};
            if (hold_v) begin
                check("stall_valid", o_out_valid, 1'b1);
                check("stall_stable", mon_cur, held);
            end
            if (o_out_valid && i_out_ready) begin
                check("word_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    mon_exp = exp_q.pop_front();
                    check("out_word", mon_cur, mon_exp);
                end
            end
            hold_v = o_out_valid && !i_out_ready;
            held   = mon_cur;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [127:0] t;
        logic [63:0]  c;
        int           n, nw;

        reset          = 1'b1;
        i_sys_enable   = 1'b1;
        i_valid_cipher = 1'b0;
        i_done         = 1'b0;
        i_out_ready    = 1'b0;
        i_cipher       = '0;
        i_tag          = '0;
        repeat (2) @(posedge clock);
        #1;
        // Pulses while reset is held must be ignored.
        i_valid_cipher = 1'b1;
        i_done         = 1'b1;
        @(posedge clock);
        #1;
        i_valid_cipher = 1'b0;
        i_done         = 1'b0;
        i_cipher       = 64'hDEAD_BEEF_DEAD_BEEF;
        i_tag          = {4{32'hBAD0_BAD0}};
        @(posedge clock);
        #1;
        reset = 1'b0;
        check_cleared("reset");
        repeat (3) cycle(1'b0, '0, 1'b0, '0, 1'b1);
        check_cleared("reset_pulses_ignored");

        // Single message with two-cycle first-word latency.
        cycle(1'b1, 64'h0123_4567_89AB_CDEF, 1'b0, '0, 1'b1);
        check("lat_n1_valid", o_out_valid, 1'b0);
        check("lat_n1_busy", o_busy, 1'b1);
        cycle(1'b0, '0, 1'b1, 128'h00112233_44556677_8899AABB_CCDDEEFF, 1'b1);
        check("lat_n2_valid", o_out_valid, 1'b1);
        check("lat_n2_data", o_out_data, 32'h0123_4567);
        drain(1'b0, "single");
        check("single_ovf", o_overflow, 1'b0);

        // Five words every 8 cycles with ready toggling.
        for (int i = 0; i < 48; i++) begin
            cycle((i % 8 == 0) && (i / 8 < 5), 64'hA5A5_0000_0000_0001 + 64'(i / 8),
                  1'b0, '0, (i % 2 == 0));
        end
        drain(1'b0, "toggle");
        check("toggle_ovf", o_overflow, 1'b0);

        // Fill output register plus FIFO, then push and pop in the same cycle.
        for (int k = 1; k <= 5; k++) begin
            cycle(1'b1, 64'hB0B0_0000_0000_0000 + 64'(k), 1'b0, '0, 1'b0);
            cycle(1'b0, '0, 1'b0, '0, 1'b0);
        end
        check("full_no_ovf", o_overflow, 1'b0);
        cycle(1'b1, 64'hB0B0_0000_0000_0006, 1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b0, '0, 1'b0);
        check("push_pop_full_ovf", o_overflow, 1'b0);
        drain(1'b1, "push_pop_full");
        check("push_pop_full_ovf_end", o_overflow, 1'b0);

        // Ready held low: the sixth word finds the FIFO full and is dropped.
        for (int k = 1; k <= 6; k++) begin
            cycle(1'b1, 64'hC0C0_0000_0000_0000 + 64'(k), 1'b0, '0, 1'b0);
            if (k < 6) cycle(1'b0, '0, 1'b0, '0, 1'b0);
        end
        check("ovf_before_drop", o_overflow, 1'b0);
        cycle(1'b0, '0, 1'b0, '0, 1'b0);
        check("ovf_after_drop", o_overflow, 1'b1);
        void'(exp_q.pop_back());
        void'(exp_q.pop_back());
        repeat (3) cycle(1'b0, '0, 1'b0, '0, 1'b0);
        check("ovf_held_word", o_out_data, 32'hC0C0_0000);
        drain(1'b0, "overflow");
        check("ovf_sticky", o_overflow, 1'b1);

        // System enable dropped while the second tag word is presented.
        t = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
        cycle(1'b1, 64'hD0D0_D0D0_0000_0001, 1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b1, t, 1'b1);
        n = 0;
        while (exp_q.size() > 3 && n < 50) begin
            cycle(1'b0, '0, 1'b0, '0, 1'b1);
            n++;
        end
        check("reach_tag1", exp_q.size(), 3);
        check("tag1_data", o_out_data, t[95:64]);
        check("tag1_is_tag", o_out_is_tag, 1'b1);
        i_sys_enable = 1'b0;
        cycle(1'b0, '0, 1'b0, '0, 1'b0);
        exp_q.delete();
        check("disable_valid", o_out_valid, 1'b0);
        check("disable_busy", o_busy, 1'b0);
        check("disable_ovf", o_overflow, 1'b0);
        i_sys_enable = 1'b1;
        cycle(1'b1, 64'hE0E0_E0E0_1234_5678, 1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b1, 128'hFEDC_BA98_7654_3210_0F1E_2D3C_4B5A_6978, 1'b1);
        drain(1'b1, "after_disable");
        check("after_disable_ovf", o_overflow, 1'b0);

        // Tag pulse arrives while cipher words are still queued.
        for (int k = 1; k <= 3; k++) begin
            cycle(1'b1, 64'hF0F0_0000_0000_0000 + 64'(k), 1'b0, '0, (k % 2 == 0));
            cycle(1'b0, '0, (k == 3), 128'hAAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000_1111, (k % 2 == 1));
        end
        check("early_tag_busy", o_busy, 1'b1);
        drain(1'b1, "early_tag");
        check("early_tag_ovf", o_overflow, 1'b0);

        // Random messages of up to four words, which always fit in register plus FIFO.
        for (int m = 0; m < 20; m++) begin
            nw = $urandom_range(4, 1);
            for (int k = 0; k < nw; k++) begin
                c = {$urandom, $urandom};
                cycle(1'b1, c, 1'b0, '0, ($urandom_range(3) != 0));
                repeat ($urandom_range(6, 3)) cycle(1'b0, '0, 1'b0, '0, ($urandom_range(3) != 0));
            end
            t = {$urandom, $urandom, $urandom, $urandom};
            cycle(1'b0, '0, 1'b1, t, ($urandom_range(3) != 0));
            drain(1'b1, "random");
            check("random_ovf", o_overflow, 1'b0);
        end

        // Reset in the middle of a stalled transfer discards everything in flight.
        cycle(1'b1, 64'h9999_8888_7777_6666, 1'b0, '0, 1'b0);
        cycle(1'b1, 64'h5555_4444_3333_2222, 1'b0, '0, 1'b0);
        cycle(1'b0, '0, 1'b0, '0, 1'b0);
        check("pre_reset_valid", o_out_valid, 1'b1);
        reset = 1'b1;
        cycle(1'b1, 64'h1234_1234_1234_1234, 1'b1, {4{32'h5678_5678}}, 1'b1);
        reset = 1'b0;
        exp_q.delete();
        check_cleared("mid_reset");
        repeat (5) cycle(1'b0, '0, 1'b0, '0, 1'b1);
        check_cleared("post_reset_quiet");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ascon_output_serializer.md
ASCON_OUTPUT_SERIALIZER -- requirements
Module: ascon_output_serializer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, number of 64-bit cipher words buffered (power of two, >=2).
REQ-002 clock  input  1  system clock; all logic rising-edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 i_sys_enable  input  1  system enable, active high; low acts as synchronous clear.
REQ-005 i_valid_cipher  input  1  one-cycle pulse from the ASCON FSM; cipher register loads on this edge.
REQ-006 i_cipher  input  64  cipher register contents.
REQ-007 i_done  input  1  one-cycle pulse from the ASCON FSM; tag register loads on this edge.
REQ-008 i_tag  input  128  tag register contents.
REQ-009 i_out_ready  input  1  downstream ready.
REQ-010 o_out_valid  output  1  o_out_data valid.
REQ-011 o_out_data  output  32  serialized word.
REQ-012 o_out_is_tag  output  1  current word belongs to the tag.
REQ-013 o_out_last  output  1  current word is tag word 3 (final word of a message).
REQ-014 o_overflow  output  1  sticky: a cipher word or tag was dropped.
REQ-015 o_busy  output  1  FIFO non-empty, tag pending, capture pending, or serializer not idle.

Function
REQ-016 Capture delay: i_valid_cipher high in cycle N -> i_cipher sampled in cycle N+1 and written to FIFO at end of N+1; same one-cycle delay for i_done -> i_tag into tag holding register.
REQ-017 Earliest o_out_valid for a captured word: cycle N+2.
REQ-018 Transfer occurs when o_out_valid && i_out_ready; o_out_data, o_out_is_tag, o_out_last stable while o_out_valid high and not accepted.
REQ-019 Each 64-bit cipher word emitted as two 32-bit words, bits [63:32] first, then [31:0].
REQ-020 Tag emitted as four words, [127:96], [95:64], [63:32], [31:0]; o_out_last high only on [31:0].
REQ-021 Tag emitted only once FIFO is empty and no cipher capture is pending; cipher words never follow a pending tag of the same message.
REQ-022 Serializer states: S_IDLE, S_CIPHER_HI, S_CIPHER_LO, S_TAG_0, S_TAG_1, S_TAG_2, S_TAG_3.
REQ-023 S_IDLE -> S_CIPHER_HI when FIFO non-empty (FIFO pop on entry, word held in output register); else -> S_TAG_0 when tag pending and no capture pending.
REQ-024 S_CIPHER_HI -> S_CIPHER_LO on transfer; S_CIPHER_LO on transfer -> S_CIPHER_HI with next pop if FIFO non-empty, else S_IDLE (no bubble between consecutive cipher words).
REQ-025 S_TAG_k -> S_TAG_k+1 on transfer; S_TAG_3 on transfer -> S_IDLE, tag-pending flag cleared.
REQ-026 FIFO write and pop in the same cycle when full: both succeed, no overflow.
REQ-027 Write when full with no pop: word dropped, o_overflow set.
REQ-028 Tag capture while tag still pending: new tag dropped, o_overflow set.
REQ-029 o_overflow clears only on reset or i_sys_enable low.
REQ-030 i_sys_enable low in any cycle: FIFO flushed, capture/tag pending cleared, state -> S_IDLE, outputs to reset values next cycle; in-flight word discarded.

Reset
REQ-031 On reset: state S_IDLE; FIFO empty; pending flags 0; o_out_valid 0; o_out_data 0; o_out_is_tag 0; o_out_last 0; o_overflow 0; o_busy 0.
REQ-032 Reset asserted mid-transfer takes effect next edge with identical result to REQ-031; i_valid_cipher/i_done during reset ignored.

Structure
REQ-033 Shared package ascon_pkg holds CIPHER_WIDTH=64, TAG_WIDTH=128, OUT_WIDTH=32 and the serializer state enum.
REQ-034 Sub-module ascon_sync_fifo (64-bit, FIFO_DEPTH entries, full/empty flags, simultaneous push/pop); serializer FSM, tag register, capture delay stay in top.

Verification
REQ-035 Single message: cipher 0x0123456789ABCDEF, tag 0x00112233_44556677_8899AABB_CCDDEEFF, ready held 1 -> words 0x01234567, 0x89ABCDEF, 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF; last only on final; first valid 2 cycles after pulse.
REQ-036 Five cipher pulses (0x...01 to 0x...05) every 8 cycles, ready toggling 1/0 each cycle -> 10 words in order, data stable during stalls, o_overflow 0.
REQ-037 Ready held 0, six cipher pulses with FIFO_DEPTH=4 -> o_overflow 1 after 6th capture (output register holds word 1, FIFO words 2-5, word 6 dropped); release ready -> words 1-5 only.
REQ-038 Full FIFO with pop and capture same cycle -> no overflow, order preserved.
REQ-039 i_sys_enable low during S_TAG_1 -> next cycle o_out_valid 0, o_busy 0, o_overflow 0; following message serializes correctly.
REQ-040 Tag pulse arriving before last cipher word drained -> all cipher words first, then tag, o_out_is_tag 1 only on tag words.
